// File: rtl/hilo_unit.sv
// HI/LO register pair and multiply sequencer: turns MULT/MULTU into an unsigned
// multiplier request, sign-corrects the returned product and commits it to HI/LO.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             op_ready,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_high,
    input  logic [WIDTH-1:0] mul_low,
    input  logic             read_req,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state, state_next;

    logic                 neg;
    logic                 accept;
    logic                 is_mul;
    logic                 is_signed;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   result;

    assign op_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign mul_start = (state == S_ISSUE);
    assign stall     = read_req && busy;
    assign accept    = op_valid && op_ready;
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_signed = (op == OP_MULT);

    // Magnitudes for the unsigned multiplier; the most negative value maps to
    // itself, which is its correct unsigned magnitude.
    assign abs_a = (is_signed && rs_data[WIDTH-1]) ? ({WIDTH{1'b0}} - rs_data) : rs_data;
    assign abs_b = (is_signed && rt_data[WIDTH-1]) ? ({WIDTH{1'b0}} - rt_data) : rt_data;

    assign prod   = {mul_high, mul_low};
    assign result = neg ? ({(2*WIDTH){1'b0}} - prod) : prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (mul_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            mul_a <= '0;
            mul_b <= '0;
            neg   <= 1'b0;
        end else begin
            if (accept) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        mul_a <= abs_a;
                        mul_b <= abs_b;
                        neg   <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    end
                    OP_MTHI: hi <= rs_data;
                    OP_MTLO: lo <= rs_data;
                    default: ;
                endcase
            end
            if (state == S_WAIT && mul_done) begin
                hi <= result[2*WIDTH-1:WIDTH];
                lo <= result[WIDTH-1:0];
            end
        end
    end

endmodule
